dtw_axil_master: RTL

- AXI4-Lite initiator that drives the dtw_accel register slave (S_AXI_*) from a simple command/response handshake port.
- Used by the control sequencer and the simulation top to program and poll the accelerator without hand-written AXI waveforms.
- One transaction is in flight at a time.
- Maintains a sticky error flag and a saturating error counter for non-OKAY responses.

---
 rtl/dtw_axil_pkg.sv | 18 +
 rtl/dtw_axil_master_if.sv | 56 +++++
 rtl/dtw_axil_master.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/dtw_axil_pkg.sv
// Shared AXI4-Lite response codes and the state encoding of the dtw_axil_master FSM.
package dtw_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RSP
    } state_t;

endpackage

// File: rtl/dtw_axil_master_if.sv
// AXI4-Lite bus bundle between the dtw_axil_master initiator and the dtw_accel register slave.
interface dtw_axil_master_if #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STROBE_WIDTH = DATA_WIDTH / 8
);

    logic                    awvalid;
    logic                    awready;
    logic [ADDR_WIDTH-1:0]   awaddr;

    logic                    wvalid;
    logic                    wready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [STROBE_WIDTH-1:0] wstrb;

    logic                    bvalid;
    logic                    bready;
    logic [1:0]              bresp;

    logic                    arvalid;
    logic                    arready;
    logic [ADDR_WIDTH-1:0]   araddr;

    logic                    rvalid;
    logic                    rready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;

    modport master (
        output awvalid, awaddr,
        input  awready,
        output wvalid, wdata, wstrb,
        input  wready,
        input  bvalid, bresp,
        output bready,
        output arvalid, araddr,
        input  arready,
        input  rvalid, rdata, rresp,
        output rready
    );

    modport slave (
        input  awvalid, awaddr,
        output awready,
        input  wvalid, wdata, wstrb,
        output wready,
        output bvalid, bresp,
        input  bready,
        input  arvalid, araddr,
        output arready,
        output rvalid, rdata, rresp,
        input  rready
    );

endinterface

// File: rtl/dtw_axil_master.sv
// Single-outstanding AXI4-Lite initiator: turns a cmd/rsp handshake into AXI-Lite transfers
// and tracks non-OKAY responses with a sticky flag and a saturating counter.
module dtw_axil_master
    import dtw_axil_pkg::*;
#(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int STROBE_WIDTH  = DATA_WIDTH / 8,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_wr,
    input  logic [ADDR_WIDTH-1:0]    cmd_addr,
    input  logic [DATA_WIDTH-1:0]    cmd_wdata,
    input  logic [STROBE_WIDTH-1:0]  cmd_wstrb,

    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_wr,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic [1:0]               rsp_resp,

    output logic                     err_sticky,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    input  logic                     err_clr,

    dtw_axil_master_if.master        m_axi
);

    state_t state, state_nxt;

    logic                    awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic [ADDR_WIDTH-1:0]   awaddr_q, araddr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STROBE_WIDTH-1:0] wstrb_q;
    logic                    aw_done, w_done;

    logic                    rsp_valid_q, rsp_wr_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic [1:0]              rsp_resp_q;

    logic                    err_sticky_q;
    logic [ERR_CNT_WIDTH-1:0] err_count_q;

    logic cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs, wr_both;
    logic cap, cap_err;
    logic [1:0] cap_resp;

    assign cmd_ready = (state == IDLE);
    assign cmd_hs    = cmd_valid & cmd_ready;
    assign aw_hs     = awvalid_q & m_axi.awready;
    assign w_hs      = wvalid_q  & m_axi.wready;
    assign b_hs      = bready_q  & m_axi.bvalid;
    assign ar_hs     = arvalid_q & m_axi.arready;
    assign r_hs      = rready_q  & m_axi.rvalid;

    // Both write channels finished, counting a handshake happening on this very edge.
    assign wr_both   = (aw_done | aw_hs) & (w_done | w_hs);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_hs)    state_nxt = cmd_wr ? WR : RD_ADDR;
            WR:      if (wr_both)   state_nxt = WR_RESP;
            WR_RESP: if (b_hs)      state_nxt = RSP;
            RD_ADDR: if (ar_hs)     state_nxt = RD_DATA;
            RD_DATA: if (r_hs)      state_nxt = RSP;
            RSP:     if (rsp_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // AXI-side registers: every valid/ready driven onto the bus comes straight from a flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awaddr_q  <= '0;
            araddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
        end else begin
            if (cmd_hs) begin
                if (cmd_wr) begin
                    awaddr_q  <= cmd_addr;
                    wdata_q   <= cmd_wdata;
                    wstrb_q   <= cmd_wstrb;
                    awvalid_q <= 1'b1;
                    wvalid_q  <= 1'b1;
                    aw_done   <= 1'b0;
                    w_done    <= 1'b0;
                end else begin
                    araddr_q  <= cmd_addr;
                    arvalid_q <= 1'b1;
                end
            end
            if (state == WR) begin
                if (aw_hs) begin
                    awvalid_q <= 1'b0;
                    aw_done   <= 1'b1;
                end
                if (w_hs) begin
                    wvalid_q <= 1'b0;
                    w_done   <= 1'b1;
                end
                if (wr_both) bready_q <= 1'b1;
            end
            if (b_hs) bready_q <= 1'b0;
            if (ar_hs) begin
                arvalid_q <= 1'b0;
                rready_q  <= 1'b1;
            end
            if (r_hs) rready_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid_q <= 1'b0;
            rsp_wr_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
        end else if (b_hs) begin
            rsp_valid_q <= 1'b1;
            rsp_wr_q    <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= m_axi.bresp;
        end else if (r_hs) begin
            rsp_valid_q <= 1'b1;
            rsp_wr_q    <= 1'b0;
            rsp_rdata_q <= m_axi.rdata;
            rsp_resp_q  <= m_axi.rresp;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign cap      = b_hs | r_hs;
    assign cap_resp = b_hs ? m_axi.bresp : m_axi.rresp;
    assign cap_err  = cap & (cap_resp != RESP_OKAY);

    // A clear on the same edge as an error wipes the history first, then records the new error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_sticky_q <= 1'b0;
            err_count_q  <= '0;
        end else if (err_clr) begin
            err_sticky_q <= cap_err;
            err_count_q  <= cap_err ? ERR_CNT_WIDTH'(1) : '0;
        end else if (cap_err) begin
            err_sticky_q <= 1'b1;
            if (err_count_q != '1) err_count_q <= err_count_q + 1'b1;
        end
    end

    assign m_axi.awvalid = awvalid_q;
    assign m_axi.awaddr  = awaddr_q;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = wstrb_q;
    assign m_axi.bready  = bready_q;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.araddr  = araddr_q;
    assign m_axi.rready  = rready_q;

    assign rsp_valid  = rsp_valid_q;
    assign rsp_wr     = rsp_wr_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_resp   = rsp_resp_q;
    assign err_sticky = err_sticky_q;
    assign err_count  = err_count_q;

endmodule
